// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations per operation.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands; undefined gives an unsigned-only divider.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd, dvs, acc;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] acc_nx, dvd_nx, q_fin, r_fin;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic             dz_reg;
    logic             accept, last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (b == '0) ? DONE : DIVIDE;
            end
            DIVIDE: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = (b == '0) ? DONE : DIVIDE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Trial subtract is WIDTH+1 bits so the borrow out decides the quotient bit.
    always_comb begin
        trial  = {acc, dvd[WIDTH-1]} - {1'b0, dvs};
        q_bit  = ~trial[WIDTH];
        acc_nx = q_bit ? trial[WIDTH-1:0] : {acc[WIDTH-2:0], dvd[WIDTH-1]};
        dvd_nx = {dvd[WIDTH-2:0], q_bit};
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q, neg_r;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
    assign q_fin = neg_q ? -dvd_nx : dvd_nx;
    assign r_fin = neg_r ? -acc_nx : acc_nx;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
        end
    end
`else
    assign a_mag = a;
    assign b_mag = b;
    assign q_fin = dvd_nx;
    assign r_fin = acc_nx;
`endif

    // Results are cleared on every accepted start so nothing partial is ever visible.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            dvd    <= '0;
            dvs    <= '0;
            acc    <= '0;
            count  <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            dz_reg <= 1'b0;
        end else if (accept) begin
            dvd   <= a_mag;
            dvs   <= b_mag;
            acc   <= '0;
            count <= '0;
            if (b == '0) begin
                q_reg  <= '1;
                r_reg  <= a;
                dz_reg <= 1'b1;
            end else begin
                q_reg  <= '0;
                r_reg  <= '0;
                dz_reg <= 1'b0;
            end
        end else if (state == DIVIDE) begin
            acc   <= acc_nx;
            dvd   <= dvd_nx;
            count <= count + CW'(1);
            if (last) begin
                q_reg <= q_fin;
                r_reg <= r_fin;
            end
        end
    end

    assign quotient    = q_reg;
    assign remainder   = r_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=16); expectations follow SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset_L;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(16)) dut (
        .clock(clock), .reset_L(reset_L), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clock);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        reset_L = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    task automatic test_unsigned;
        int lat;
        start_op(16'd100, 16'd7);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== 16'd0) begin
            errors++;
            $display("FAIL divide_state: got busy=%b done=%b q=%h required busy=1 done=0 q=0", busy, done, quotient);
        end
        wait_done(lat);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL latency_100_7: got %0d required 16", lat); end
        checks++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL result_100_7: got q=%0d r=%0d dz=%b busy=%b required q=14 r=2 dz=0 busy=0",
                     quotient, remainder, div_by_zero, busy);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b1 || quotient !== 16'd14 || remainder !== 16'd2) begin
            errors++;
            $display("FAIL done_hold: got done=%b q=%0d r=%0d required done=1 q=14 r=2", done, quotient, remainder);
        end
    endtask

    task automatic test_vectors;
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic [15:0] eq [6];
        logic [15:0] er [6];
        int lat;
        va[0] = 16'hFF9C; vb[0] = 16'd7;
        va[1] = 16'd1000; vb[1] = 16'd3;    eq[1] = 16'd333;  er[1] = 16'd1;
        va[2] = 16'd7;    vb[2] = 16'd100;  eq[2] = 16'd0;    er[2] = 16'd7;
        va[3] = 16'hFFFF; vb[3] = 16'd1;    eq[3] = 16'hFFFF; er[3] = 16'd0;
        va[4] = 16'h8000; vb[4] = 16'hFFFF;
        va[5] = 16'd100;  vb[5] = 16'hFFF9;
`ifdef SEQ_DIVIDER_SIGNED_EN
        eq[0] = 16'hFFF2; er[0] = 16'hFFFE;
        eq[4] = 16'h8000; er[4] = 16'd0;
        eq[5] = 16'hFFF2; er[5] = 16'd2;
`else
        eq[0] = 16'd9348; er[0] = 16'd0;
        eq[4] = 16'd0;    er[4] = 16'h8000;
        eq[5] = 16'd0;    er[5] = 16'd100;
`endif
        for (int i = 0; i < 6; i++) begin
            start_op(va[i], vb[i]);
            wait_done(lat);
            checks++;
            if (lat !== 16 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL vector_%0d (%h/%h): got lat=%0d q=%h r=%h dz=%b required lat=16 q=%h r=%h dz=0",
                         i, va[i], vb[i], lat, quotient, remainder, div_by_zero, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_zero_divisor;
        int lat;
        start_op(16'd5, 16'd0);
        lat = done ? 1 : 0;
        if (!done) wait_done(lat);
        checks++;
        if (lat !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dz_latency: got lat=%0d busy=%b required lat=1 busy=0", lat, busy);
        end
        checks++;
        if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_result: got q=%h r=%h dz=%b required q=ffff r=0005 dz=1", quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        start_op(16'd1000, 16'd3);
        repeat (7) @(posedge clock);
        #2;
        reset_L = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b dz=%b q=%h r=%h required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clock);
        reset_L = 1'b1;
        a = 16'd9; b = 16'd9; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL first_edge_accept: got busy=%b required 1", busy); end
        wait_done(lat);
        checks++;
        if (lat !== 16 || quotient !== 16'd1 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL after_abort: got lat=%0d q=%0d r=%0d required lat=16 q=1 r=0", lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clock);
        a = 16'd3; b = 16'd9; start = 1'b1;
        @(posedge clock);
        #1;
        a = 16'd50; b = 16'd5;
        wait_done(lat);
        checks++;
        if (lat !== 16 || quotient !== 16'd0 || remainder !== 16'd3) begin
            errors++;
            $display("FAIL start_held: got lat=%0d q=%0d r=%0d required lat=16 q=0 r=3", lat, quotient, remainder);
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || quotient !== 16'd0 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL restart_from_done: got done=%b busy=%b q=%0d r=%0d required done=0 busy=1 q=0 r=0",
                     done, busy, quotient, remainder);
        end
        wait_done(lat);
        checks++;
        if (lat !== 16 || quotient !== 16'd10 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL back_to_back: got lat=%0d q=%0d r=%0d required lat=16 q=10 r=0", lat, quotient, remainder);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_vectors();
        test_zero_divisor();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; legal range 4..32.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset_L  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request; sampled on rising edge in IDLE or DONE only.
REQ-005 Port: a  input  WIDTH  dividend, captured on the accepted start edge.
REQ-006 Port: b  input  WIDTH  divisor, captured on the accepted start edge.
REQ-007 Port: busy  output  1  high while in DIVIDE.
REQ-008 Port: done  output  1  high while in DONE; results valid while high.
REQ-009 Port: quotient  output  WIDTH  a / b.
REQ-010 Port: remainder  output  WIDTH  a mod b.
REQ-011 Port: div_by_zero  output  1  captured b was zero; valid while done.

Function
REQ-012 FSM states: IDLE, DIVIDE and DONE only; no other state is reachable.
REQ-013 IDLE with start=1 -> capture operands, clear remainder accumulator and iteration counter, go to DIVIDE; with start=0 -> stay in IDLE.
REQ-014 Algorithm: restoring shift-subtract on magnitudes; each DIVIDE edge shifts accumulator left, shifts in the next dividend MSB, trial-subtracts divisor magnitude (WIDTH+1-bit), and keeps the difference with quotient bit 1 if non-negative, else restores with bit 0.
REQ-015 DIVIDE performs exactly WIDTH iterations, one per edge; the edge completing iteration WIDTH moves to DONE.
REQ-016 Latency: done rises exactly WIDTH edges after the start-accepting edge (16 for default).
REQ-017 start is ignored in DIVIDE; a, b changes after capture do not affect the result.
REQ-018 DONE holds quotient, remainder, div_by_zero stable until the next accepted start.
REQ-019 DONE with start=1 -> behaves as IDLE with start=1 (back-to-back operation, done drops next cycle).
REQ-020 DONE with start=0 -> stays in DONE.
REQ-021 b==0 at capture -> skip DIVIDE, enter DONE on the next edge with div_by_zero=1, quotient all ones, remainder = a.
REQ-022 Results satisfy a == quotient*b + remainder (mod 2^WIDTH), |remainder| < |b|, for every b != 0.
REQ-023 quotient/remainder/div_by_zero are 0 in IDLE and DIVIDE; busy and done are never high together.

Reset
REQ-024 reset_L=0 forces IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 immediately, regardless of clock.
REQ-025 Reset mid-DIVIDE aborts the operation; no partial result is ever presented.
REQ-026 The first rising edge after reset_L deasserts may accept start.

Configuration
REQ-027 Macro SEQ_DIVIDER_SIGNED_EN defined: a, b are two's complement; magnitudes are divided; quotient is negated when the sign of a differs from that of b (truncation toward zero); remainder takes the sign of a; most-negative / -1 yields quotient = most-negative, remainder = 0.
REQ-028 Macro SEQ_DIVIDER_SIGNED_EN undefined: a, b are unsigned; no sign logic is synthesized.
REQ-029 Latency, handshake, divide-by-zero and reset behaviour are identical in both builds.

Verification
REQ-030 Unsigned: a=100, b=7, start one cycle -> done after 16 edges, quotient=14, remainder=2, div_by_zero=0.
REQ-031 Sign: a=16'hFF9C, b=7 -> signed build quotient=16'hFFF2, remainder=16'hFFFE; unsigned build quotient=9348, remainder=0.
REQ-032 Zero divisor: a=5, b=0 -> done one edge after start, div_by_zero=1, quotient=16'hFFFF, remainder=5.
REQ-033 Reset abort: a=1000, b=3, reset_L low at DIVIDE edge 8 -> all outputs 0 at once; new start a=9, b=9 -> quotient=1, remainder=0 after 16 edges.
REQ-034 Handshake: start held high through DIVIDE with a=3, b=9 -> quotient=0, remainder=3 after 16 edges; start in DONE with a=50, b=5 -> done drops, returns 16 edges later with quotient=10, remainder=0.
REQ-035 Signed build: a=16'h8000, b=16'hFFFF -> quotient=16'h8000, remainder=0, div_by_zero=0.
